// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin arbiter that merges NUM_CH AXI-Stream TX sources
// into one MAC TX stream, one whole packet at a time.
//
// Ports:
//   clock, resetn            rising-edge clock, synchronous active-low reset
//   s_axis_t*                per-channel source streams, channel c packed at
//                            [c*W +: W]; s_axis_tready one bit per channel
//   m_axis_t*                merged MAC stream (m_axis_tuser = 1 marks a bad frame)
//   grant                    one-hot owner of the output, zero while idle
//   busy                     high while a packet is locked or being drained
//   frame_count, trunc_count statistics, present only with ETH_TX_ARBITER_STATS_EN
//
// Packets longer than MAX_BEATS are cut: beat MAX_BEATS leaves with tlast and
// tuser set, and the rest of the source packet is accepted and thrown away.
//
// Optional feature macro: ETH_TX_ARBITER_STATS_EN (per-channel frame counters
// and a saturating truncation counter).
module eth_tx_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned MAX_BEATS = 192
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [NUM_CH*DATA_BITS-1:0]     s_axis_tdata,
  input  logic [NUM_CH*(DATA_BITS/8)-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]               s_axis_tlast,
  input  logic [NUM_CH-1:0]               s_axis_tuser,
  input  logic [NUM_CH-1:0]               s_axis_tvalid,
  output logic [NUM_CH-1:0]               s_axis_tready,
  output logic [DATA_BITS-1:0]            m_axis_tdata,
  output logic [DATA_BITS/8-1:0]          m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [NUM_CH-1:0]               grant,
`ifdef ETH_TX_ARBITER_STATS_EN
  output logic [NUM_CH*16-1:0]            frame_count,
  output logic [15:0]                     trunc_count,
`endif
  output logic                            busy
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned SelW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW      = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StLock, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  // Selected source channel
  logic [DATA_BITS-1:0] src_data;
  logic [KEEP_BITS-1:0] src_keep;
  logic                 src_last, src_user, src_valid;

  assign src_data  = s_axis_tdata[sel_q*DATA_BITS +: DATA_BITS];
  assign src_keep  = s_axis_tkeep[sel_q*KEEP_BITS +: KEEP_BITS];
  assign src_last  = s_axis_tlast[sel_q];
  assign src_user  = s_axis_tuser[sel_q];
  assign src_valid = s_axis_tvalid[sel_q];

  // Channel after the current owner, with wrap; it gets first priority next time.
  logic [SelW-1:0] sel_inc;
  assign sel_inc = (32'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;

  // Round-robin pick: first valid channel at or above rr_ptr, wrapping.
  logic            pick_found;
  logic [SelW-1:0] pick_idx;
  logic [SelW-1:0] cand_idx;
  int unsigned     cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_CH;
      cand_idx = SelW'(cand);
      if (!pick_found && s_axis_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Accepted output beat and whether it is a forced truncation.
  logic m_fire;
  logic trunc_beat;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    grant         = '0;
    busy          = 1'b0;
    m_fire        = 1'b0;
    trunc_beat    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          sel_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = StLock;
        end
      end

      StLock: begin
        busy           = 1'b1;
        grant[sel_q]   = 1'b1;
        // Beat number MAX_BEATS without a source tlast is closed off here.
        trunc_beat     = (beat_cnt_q == CntW'(MAX_BEATS - 1)) && !src_last;
        m_axis_tdata   = src_data;
        m_axis_tkeep   = src_keep;
        m_axis_tlast   = src_last | trunc_beat;
        m_axis_tuser   = src_user | trunc_beat;
        m_axis_tvalid  = src_valid;
        s_axis_tready[sel_q] = m_axis_tready;
        m_fire         = src_valid && m_axis_tready;
        if (m_fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (src_last) begin
            state_d  = StIdle;
            rr_ptr_d = sel_inc;
          end else if (trunc_beat) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        // Swallow the tail of a truncated packet without forwarding it.
        busy                 = 1'b1;
        grant[sel_q]         = 1'b1;
        s_axis_tready[sel_q] = 1'b1;
        if (src_valid && src_last) begin
          state_d  = StIdle;
          rr_ptr_d = sel_inc;
        end
      end

      default: state_d = StIdle;
    endcase

    // Keep the handshake quiet while reset is asserted, even before the edge.
    if (!resetn) begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      grant         = '0;
      busy          = 1'b0;
      m_fire        = 1'b0;
      trunc_beat    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef ETH_TX_ARBITER_STATS_EN
  logic [NUM_CH*16-1:0] frame_cnt_q;
  logic [15:0]          trunc_cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      // Counts every closing beat, including forced truncations; wraps.
      if (m_fire && m_axis_tlast) begin
        frame_cnt_q[sel_q*16 +: 16] <= frame_cnt_q[sel_q*16 +: 16] + 16'd1;
      end
      if (m_fire && trunc_beat && (trunc_cnt_q != 16'hFFFF)) begin
        trunc_cnt_q <= trunc_cnt_q + 16'd1;
      end
    end
  end

  assign frame_count = frame_cnt_q;
  assign trunc_count = trunc_cnt_q;
`endif

endmodule
